// File: rtl/ahb_slave_regfile.sv
// ahb_slave_regfile: AHB-lite word-addressed register file with wait states and 2-cycle ERROR.
// Define AHB_SLV_RDONLY_EN to make address 0 a read-only ID register (ID_VALUE).
module ahb_slave_regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR = 32,
  parameter int DEPTH = 16,
  parameter int WAIT_STATES = 0
`ifdef AHB_SLV_RDONLY_EN
  , parameter logic [DATA_WIDTH-1:0] ID_VALUE = 32'hA5B00001
`endif
) (
  input  logic                  i_clk_ahb,
  input  logic                  i_rstn_ahb,
  input  logic                  i_hsel,
  input  logic [ADDR-1:0]       i_haddr,
  input  logic                  i_htrans,
  input  logic                  i_hwrite,
  input  logic [2:0]            i_hsize,
  input  logic [DATA_WIDTH-1:0] i_hwdata,
  output logic                  o_hready,
  output logic                  o_hresp,
  output logic [DATA_WIDTH-1:0] o_hrdata
);
  localparam int IW = $clog2(DEPTH);
  typedef enum logic [2:0] {IDLE, WAIT, DATA, ERR1, ERR2} state_t;
  state_t state, nxt;
  logic [IW-1:0] addr_q;
  logic write_q, accept, err, ro_err;
  logic [3:0] cnt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_val;
`ifdef AHB_SLV_RDONLY_EN
  assign ro_err = i_hwrite && i_haddr == '0;
  assign rd_val = addr_q == '0 ? ID_VALUE : mem[addr_q];
`else
  assign ro_err = 1'b0;
  assign rd_val = mem[addr_q];
`endif
  assign accept = i_hsel & i_htrans & o_hready;
  // range check uses the full address width so high bits never alias into the file
  assign err = (i_haddr >= ADDR'(DEPTH)) | (i_hsize != 3'b010) | ro_err;
  always_comb nxt = state == WAIT ? (cnt == 4'(WAIT_STATES - 1) ? DATA : WAIT) :
                    state == ERR1 ? ERR2 :
                    !accept ? IDLE :
                    err ? ERR1 :
                    WAIT_STATES > 0 ? WAIT : DATA;
  always_ff @(posedge i_clk_ahb)
    if (!i_rstn_ahb) begin
      state <= IDLE;
      o_hready <= 1'b1;
      o_hresp <= 1'b0;
      cnt <= '0;
      addr_q <= '0;
      write_q <= 1'b0;
      mem <= '{default: '0};
    end else begin
      if (state == DATA && write_q) mem[addr_q] <= i_hwdata;
      if (accept) begin
        addr_q <= i_haddr[IW-1:0];
        write_q <= i_hwrite;
      end
      state <= nxt;
      cnt <= (state == WAIT && nxt == WAIT) ? cnt + 4'd1 : '0;
      o_hready <= nxt inside {IDLE, DATA, ERR2};
      o_hresp <= nxt inside {ERR1, ERR2};
    end
  assign o_hrdata = (state == DATA && !write_q) ? rd_val : '0;
endmodule

// File: tb/tb_ahb_slave_regfile.sv
// tb_ahb_slave_regfile: directed and random transfers on a zero-wait and a two-wait slave,
// checked against an array model of the register file.
module tb_ahb_slave_regfile;
  localparam logic [31:0] ID = 32'hA5B00001;
`ifdef AHB_SLV_RDONLY_EN
  localparam bit RO = 1'b1;
`else
  localparam bit RO = 1'b0;
`endif
  logic clk = 0, rstn = 0, hsel = 0, htrans = 0, hwrite = 0;
  logic [31:0] haddr = '0, hwdata = '0;
  logic [2:0] hsize = 3'b010;
  int dsel = 0;
  logic rdy0, rsp0, rdy1, rsp1;
  logic [31:0] rd0, rd1;
  int vectors = 0, miscompares = 0;
  logic [31:0] mdl [2][16];
  always #5 clk = ~clk;
  ahb_slave_regfile #(.WAIT_STATES(0)) u0 (
    .i_clk_ahb(clk), .i_rstn_ahb(rstn), .i_hsel(hsel && dsel == 0), .i_haddr(haddr),
    .i_htrans(htrans), .i_hwrite(hwrite), .i_hsize(hsize), .i_hwdata(hwdata),
    .o_hready(rdy0), .o_hresp(rsp0), .o_hrdata(rd0));
  ahb_slave_regfile #(.WAIT_STATES(2)) u2 (
    .i_clk_ahb(clk), .i_rstn_ahb(rstn), .i_hsel(hsel && dsel == 1), .i_haddr(haddr),
    .i_htrans(htrans), .i_hwrite(hwrite), .i_hsize(hsize), .i_hwdata(hwdata),
    .o_hready(rdy1), .o_hresp(rsp1), .o_hrdata(rd1));
  function automatic int ws(input int d);
    return d == 1 ? 2 : 0;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic cur(output logic r, output logic p, output logic [31:0] q);
    r = dsel == 1 ? rdy1 : rdy0;
    p = dsel == 1 ? rsp1 : rsp0;
    q = dsel == 1 ? rd1 : rd0;
  endtask
  task automatic clear_model();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 16; i++) mdl[d][i] = '0;
  endtask
  // one complete transfer from an idle bus; called just after a rising edge
  task automatic xfer(input string tag, input int d, input bit w, input logic [31:0] a,
                      input logic [2:0] sz, input logic [31:0] wd);
    bit e;
    int lows;
    logic r, p, first_p;
    logic [31:0] q, exp;
    e = a >= 16 || sz != 3'b010 || (RO && w && a == 0);
    exp = (e || w) ? 32'h0 : (RO && a == 0) ? ID : mdl[d][a[3:0]];
    dsel = d; hsel = 1; htrans = 1; hwrite = w; haddr = a; hsize = sz;
    @(posedge clk); #1;
    hsel = 0; htrans = 0; hwdata = wd;
    lows = 0; first_p = 1'bx; r = 0; p = 0; q = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cur(r, p, q);
      if (i == 0) first_p = p;
      if (r) break;
      lows++;
    end
    chk({tag, ".lows"}, lows, e ? 1 : ws(d));
    chk({tag, ".resp_first"}, first_p, e);
    chk({tag, ".resp_last"}, p, e);
    chk({tag, ".rdata"}, q, exp);
    if (!e && w) mdl[d][a[3:0]] = wd;
    @(posedge clk); #1;
  endtask
  initial begin
    logic r, p;
    logic [31:0] q;
    clear_model();
    repeat (3) @(posedge clk);
    #1 rstn = 1;
    @(negedge clk);
    chk("rst.rdy0", rdy0, 1); chk("rst.rsp0", rsp0, 0); chk("rst.rd0", rd0, 0);
    chk("rst.rdy1", rdy1, 1); chk("rst.rsp1", rsp1, 0); chk("rst.rd1", rd1, 0);
    @(posedge clk); #1;
    xfer("t1.wr5", 0, 1, 5, 3'b010, 32'hA1A2A3A4);
    xfer("t1.rd5", 0, 0, 5, 3'b010, 32'h0);
    // write @6 with read @6 issued in the write's data phase
    dsel = 0; hsel = 1; htrans = 1; hwrite = 1; haddr = 6; hsize = 3'b010;
    @(posedge clk); #1;
    hwdata = 32'hB1B2B3B4; hwrite = 0;
    @(negedge clk);
    chk("t2.wr_rdy", rdy0, 1);
    @(posedge clk); #1;
    hsel = 0; htrans = 0;
    mdl[0][6] = 32'hB1B2B3B4;
    @(negedge clk);
    chk("t2.rd_rdy", rdy0, 1); chk("t2.rd_resp", rsp0, 0); chk("t2.rd_data", rd0, 32'hB1B2B3B4);
    @(posedge clk); #1;
    xfer("t3.wr7", 1, 1, 7, 3'b010, 32'hABCD1234);
    xfer("t3.rd7", 1, 0, 7, 3'b010, 32'h0);
    xfer("t4.wr22", 0, 1, 32'h22, 3'b010, 32'h12345678);
    xfer("t4.alias", 0, 1, 32'h1000_0005, 3'b010, 32'h55555555);
    for (int i = 0; i < 16; i++) xfer($sformatf("t4.rd%0d", i), 0, 0, i, 3'b010, 32'h0);
    xfer("t5.size", 0, 0, 3, 3'b000, 32'h0);
    xfer("t5.size_wr", 1, 1, 3, 3'b001, 32'hFFFF0000);
    xfer("t6.pre", 1, 1, 4, 3'b010, 32'h44444444);
    dsel = 1; hsel = 1; htrans = 1; hwrite = 1; haddr = 4; hsize = 3'b010;
    @(posedge clk); #1;
    hsel = 0; htrans = 0; hwdata = 32'hDEADBEEF; rstn = 0;
    @(posedge clk); #1;
    rstn = 1;
    clear_model();
    @(negedge clk);
    cur(r, p, q);
    chk("t6.rdy", r, 1); chk("t6.resp", p, 0);
    @(posedge clk); #1;
    xfer("t6.rd4", 1, 0, 4, 3'b010, 32'h0);
    xfer("t7.rd0", 0, 0, 0, 3'b010, 32'h0);
    xfer("t7.wr0", 0, 1, 0, 3'b010, 32'h77777777);
    xfer("t7.rd0b", 0, 0, 0, 3'b010, 32'h0);
    for (int n = 0; n < 80; n++) begin
      int d;
      bit w;
      logic [31:0] a;
      logic [2:0] sz;
      d = int'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      a = $urandom_range(0, 19);
      sz = $urandom_range(0, 7) == 0 ? 3'($urandom_range(0, 7)) : 3'b010;
      xfer($sformatf("rnd%0d", n), d, w, a, sz, $urandom);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 16; i++) xfer($sformatf("fin%0d.%0d", d, i), d, 0, i, 3'b010, 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
